// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: data-memory controller state encoding and
// access-size encodings used by the M-stage and the bus side.
package cpu_bus_pkg;

  localparam int unsigned SIZE_W = 2;
  localparam int unsigned WEN_W  = 4;

  // Access size encoding carried on mem_size_i / size_o
  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

  // Data-memory controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage : cpu_bus_pkg

// File: rtl/data_sram_ctrl.sv
// Data SRAM controller: turns an M-stage load/store into a single
// request/response bus transaction, stalls the pipeline while it is in
// flight and buffers load data until the M stage advances.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_en_i, mem_wen_i,     M-stage access: enable, byte strobes (0 = read),
//   mem_size_i, mem_addr_i,  size, byte address,
//   mem_wdata_i              lane-aligned store data
//   mem_flush_i              M-stage instruction cancelled
//   pipe_adv_i               M stage advances this edge
//   mem_rdata_o              buffered load data
//   mem_stall_o              pipeline freeze (combinational)
//   req_o, wr_o, size_o,     bus request side, held stable from registers
//   addr_o, wdata_o
//   addr_ok_i, data_ok_i,    bus request accept, response valid, response data
//   rdata_i
module data_sram_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en_i,
  input  logic [WEN_W-1:0]    mem_wen_i,
  input  logic [SIZE_W-1:0]   mem_size_i,
  input  logic [DW-1:0]       mem_addr_i,
  input  logic [DW-1:0]       mem_wdata_i,
  input  logic                mem_flush_i,
  input  logic                pipe_adv_i,
  output logic [DW-1:0]       mem_rdata_o,
  output logic                mem_stall_o,
  output logic                req_o,
  output logic                wr_o,
  output logic [SIZE_W-1:0]   size_o,
  output logic [DW-1:0]       addr_o,
  output logic [DW-1:0]       wdata_o,
  input  logic                addr_ok_i,
  input  logic                data_ok_i,
  input  logic [DW-1:0]       rdata_i
);

  mem_state_e          state_q,  state_d;
  logic                cancel_q, cancel_d;
  logic                req_q,    req_d;
  logic                wr_q,     wr_d;
  logic [SIZE_W-1:0]   size_q,   size_d;
  logic [DW-1:0]       addr_q,   addr_d;
  logic [DW-1:0]       wdata_q,  wdata_d;
  logic [DW-1:0]       rdata_q,  rdata_d;

  // Next-state and buffer update
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_en_i && !mem_flush_i) begin
          wr_d     = |mem_wen_i;
          size_d   = mem_size_i;
          addr_d   = mem_addr_i;
          wdata_d  = mem_wdata_i;
          cancel_d = 1'b0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // A driven request cannot be withdrawn; a flush only marks it cancelled
        if (mem_flush_i) cancel_d = 1'b1;
        if (addr_ok_i)   state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_flush_i) cancel_d = 1'b1;
        if (data_ok_i) begin
          // A flush arriving with the response still cancels it
          if (cancel_q || mem_flush_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            if (!wr_q) rdata_d = rdata_i;
          end
        end
      end
      ST_DONE: begin
        // mem_en_i is ignored here so the completed access is not reissued
        if (mem_flush_i || pipe_adv_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_d = (state_d == ST_REQ);
  end

  // State and buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Stall covers the issue cycle in IDLE plus the whole in-flight window
  assign mem_stall_o = ((state_q == ST_IDLE) && mem_en_i && !mem_flush_i) ||
                       (state_q == ST_REQ) || (state_q == ST_WAIT);

  assign req_o       = req_q;
  assign wr_o        = wr_q;
  assign size_o      = size_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign mem_rdata_o = rdata_q;

endmodule : data_sram_ctrl

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: loads, stores, flushes in each state,
// DONE hold, back-to-back loads and reset mid-transaction.
module tb_data_sram_ctrl;
  import cpu_bus_pkg::*;

  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst;
  logic            mem_en;
  logic [3:0]      mem_wen;
  logic [1:0]      mem_size;
  logic [DW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_flush;
  logic            pipe_adv;
  logic [DW-1:0]   mem_rdata;
  logic            mem_stall;
  logic            req;
  logic            wr;
  logic [1:0]      size;
  logic [DW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            addr_ok;
  logic            data_ok;
  logic [DW-1:0]   rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_base  = 0;

  data_sram_ctrl #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en_i    (mem_en),
    .mem_wen_i   (mem_wen),
    .mem_size_i  (mem_size),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_flush_i (mem_flush),
    .pipe_adv_i  (pipe_adv),
    .mem_rdata_o (mem_rdata),
    .mem_stall_o (mem_stall),
    .req_o       (req),
    .wr_o        (wr),
    .size_o      (size),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .addr_ok_i   (addr_ok),
    .data_ok_i   (data_ok),
    .rdata_i     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted bus requests
  always @(posedge clk) begin
    if (req && addr_ok) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus_idle(input string tag);
    check_eq({tag, "_req"},   32'(req),   32'd0);
    check_eq({tag, "_wr"},    32'(wr),    32'd0);
    check_eq({tag, "_size"},  32'(size),  32'd0);
    check_eq({tag, "_addr"},  addr,       32'd0);
    check_eq({tag, "_wdata"}, wdata,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_wen = 4'd0; mem_size = SZ_BYTE;
    mem_addr = '0; mem_wdata = '0; mem_flush = 1'b0; pipe_adv = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;

    // Reset state
    #3;
    check_bus_idle("rst");
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);
    mem_en = 1'b1; #1;
    check_eq("rst_stall_en", 32'(mem_stall), 32'd1);
    mem_en = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Word load, minimum latency
    mem_en = 1'b1; mem_wen = 4'd0; mem_size = SZ_WORD; mem_addr = 32'h8000_1000; #1;
    check_eq("ld_c0_stall", 32'(mem_stall), 32'd1);
    check_eq("ld_c0_req", 32'(req), 32'd0);
    cyc();
    addr_ok = 1'b1; #1;
    check_eq("ld_c1_req", 32'(req), 32'd1);
    check_eq("ld_c1_addr", addr, 32'h8000_1000);
    check_eq("ld_c1_size", 32'(size), 32'(SZ_WORD));
    check_eq("ld_c1_wr", 32'(wr), 32'd0);
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    check_eq("ld_c2_req", 32'(req), 32'd0);
    check_eq("ld_c2_stall", 32'(mem_stall), 32'd1);
    cyc();
    data_ok = 1'b0; rdata = '0; mem_en = 1'b0; #1;
    check_eq("ld_c3_rdata", mem_rdata, 32'hDEAD_BEEF);
    check_eq("ld_c3_stall", 32'(mem_stall), 32'd0);
    pipe_adv = 1'b1;
    cyc();
    pipe_adv = 1'b0;

    // Byte store with addr_ok delayed three cycles
    mem_en = 1'b1; mem_wen = 4'b0001; mem_size = SZ_BYTE;
    mem_addr = 32'h8000_2003; mem_wdata = 32'h0000_00AB; #1;
    check_eq("st_c0_stall", 32'(mem_stall), 32'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      addr_ok = (i == 3); #1;
      check_eq("st_req", 32'(req), 32'd1);
      check_eq("st_wr", 32'(wr), 32'd1);
      check_eq("st_size", 32'(size), 32'(SZ_BYTE));
      check_eq("st_wdata", wdata, 32'h0000_00AB);
      check_eq("st_addr", addr, 32'h8000_2003);
      cyc();
    end
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1234_5678; #1;
    check_eq("st_wait_req", 32'(req), 32'd0);
    check_eq("st_wait_stall", 32'(mem_stall), 32'd1);
    cyc();
    data_ok = 1'b0; mem_en = 1'b0; mem_wen = 4'd0; #1;
    check_eq("st_done_stall", 32'(mem_stall), 32'd0);
    check_eq("st_done_rdata", mem_rdata, 32'hDEAD_BEEF);
    pipe_adv = 1'b1;
    cyc();
    pipe_adv = 1'b0;

    // Flush during WAIT on a load
    mem_en = 1'b1; mem_size = SZ_WORD; mem_addr = 32'h8000_3000; #1;
    cyc();
    addr_ok = 1'b1; #1;
    cyc();
    addr_ok = 1'b0; mem_flush = 1'b1; #1;
    check_eq("fw_flush_stall", 32'(mem_stall), 32'd1);
    cyc();
    mem_flush = 1'b0; data_ok = 1'b1; rdata = 32'h5555_5555; #1;
    check_eq("fw_drain_stall", 32'(mem_stall), 32'd1);
    cyc();
    data_ok = 1'b0; mem_en = 1'b0; #1;
    check_eq("fw_after_stall", 32'(mem_stall), 32'd0);
    check_eq("fw_after_req", 32'(req), 32'd0);
    check_eq("fw_after_rdata", mem_rdata, 32'hDEAD_BEEF);
    // Stall with mem_en proves IDLE rather than DONE
    mem_en = 1'b1; mem_addr = 32'h8000_4000; #1;
    check_eq("fw_idle", 32'(mem_stall), 32'd1);
    cyc();

    // Flush coincident with data_ok counts as cancelled
    addr_ok = 1'b1; #1;
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; mem_flush = 1'b1; rdata = 32'h7777_7777; #1;
    check_eq("fd_stall", 32'(mem_stall), 32'd1);
    cyc();
    data_ok = 1'b0; mem_flush = 1'b0; mem_addr = 32'h8000_5000; #1;
    check_eq("fd_idle", 32'(mem_stall), 32'd1);
    check_eq("fd_rdata", mem_rdata, 32'hDEAD_BEEF);
    cyc();

    // DONE held with pipe_adv low, rdata toggling, mem_en high
    addr_ok = 1'b1; #1;
    check_eq("dh_addr", addr, 32'h8000_5000);
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D; #1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      data_ok = i[0];
      rdata = i[0] ? 32'hFFFF_FFFF : 32'h0000_0000; #1;
      check_eq("dh_rdata", mem_rdata, 32'hCAFE_F00D);
      check_eq("dh_req", 32'(req), 32'd0);
      check_eq("dh_stall", 32'(mem_stall), 32'd0);
      cyc();
    end
    data_ok = 1'b0;
    // Flush in DONE returns to IDLE
    mem_flush = 1'b1; #1;
    cyc();
    mem_flush = 1'b0; mem_addr = 32'h8000_6000; #1;
    check_eq("fdone_idle", 32'(mem_stall), 32'd1);
    check_eq("fdone_rdata", mem_rdata, 32'hCAFE_F00D);

    // Back-to-back loads
    hs_base = hs_cnt;
    cyc();
    addr_ok = 1'b1; #1;
    check_eq("b2b_a_addr", addr, 32'h8000_6000);
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_1111; #1;
    cyc();
    data_ok = 1'b0; pipe_adv = 1'b1; #1;
    check_eq("b2b_a_rdata", mem_rdata, 32'h1111_1111);
    cyc();
    pipe_adv = 1'b0; mem_addr = 32'h8000_7000; #1;
    check_eq("b2b_b_stall", 32'(mem_stall), 32'd1);
    cyc();
    addr_ok = 1'b1; #1;
    check_eq("b2b_b_addr", addr, 32'h8000_7000);
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2222_2222; #1;
    cyc();
    data_ok = 1'b0; mem_en = 1'b0; #1;
    check_eq("b2b_b_rdata", mem_rdata, 32'h2222_2222);
    check_eq("b2b_hs", 32'(hs_cnt - hs_base), 32'd2);
    pipe_adv = 1'b1;
    cyc();
    pipe_adv = 1'b0;

    // Flush in IDLE issues nothing
    mem_en = 1'b1; mem_flush = 1'b1; mem_addr = 32'h8000_7100; #1;
    check_eq("fidle_stall", 32'(mem_stall), 32'd0);
    cyc();
    mem_en = 1'b0; mem_flush = 1'b0; #1;
    check_eq("fidle_req", 32'(req), 32'd0);
    check_eq("fidle_addr", addr, 32'h8000_7000);

    // Reset in WAIT, late data_ok after release
    mem_en = 1'b1; mem_size = SZ_HALF; mem_addr = 32'h8000_8000; #1;
    cyc();
    addr_ok = 1'b1; #1;
    cyc();
    addr_ok = 1'b0; mem_en = 1'b0; #1;
    check_eq("rw_wait_stall", 32'(mem_stall), 32'd1);
    rst = 1'b1; #1;
    check_bus_idle("rw_rst");
    check_eq("rw_rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rw_rst_rdata", mem_rdata, 32'd0);
    cyc();
    rst = 1'b0; data_ok = 1'b1; rdata = 32'h9999_9999; #1;
    cyc();
    data_ok = 1'b0; #1;
    check_bus_idle("rw_late");
    check_eq("rw_late_rdata", mem_rdata, 32'd0);
    check_eq("rw_late_stall", 32'(mem_stall), 32'd0);
    mem_en = 1'b1; #1;
    check_eq("rw_late_idle", 32'(mem_stall), 32'd1);
    mem_en = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_sram_ctrl

// File: doc/data_sram_ctrl.md
DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 Parameter DW, default 32, SHALL set the data and address width.
REQ-002 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port mem_en_i, input, 1: the M-stage instruction is a load or store.
REQ-005 Port mem_wen_i, input, 4: byte write strobes; 0 means read.
REQ-006 Port mem_size_i, input, 2: access size, encoded 0 = byte, 1 = half, 2 = word.
REQ-007 Port mem_addr_i, input, DW: byte address.
REQ-008 Port mem_wdata_i, input, DW: store data, already lane-aligned.
REQ-009 Port mem_flush_i, input, 1: the M-stage instruction is cancelled by an exception.
REQ-010 Port pipe_adv_i, input, 1: the M stage advances on this edge.
REQ-011 Port mem_rdata_o, output, DW: buffered load data.
REQ-012 Port mem_stall_o, output, 1: freeze the pipeline.
REQ-013 Port req_o, output, 1: bus request.
REQ-014 Port wr_o, output, 1: bus write.
REQ-015 Port size_o, output, 2: bus size.
REQ-016 Port addr_o, output, DW: bus address.
REQ-017 Port wdata_o, output, DW: bus write data.
REQ-018 Port addr_ok_i, input, 1: request accepted.
REQ-019 Port data_ok_i, input, 1: response valid.
REQ-020 Port rdata_i, input, DW: response data.

Function
REQ-021 The block SHALL implement four states, IDLE, REQ, WAIT and DONE, with at most one outstanding bus transaction.
REQ-022 IDLE: if mem_en_i and not mem_flush_i, the block SHALL latch addr, wdata, size and wr (wr = |mem_wen_i) into registers, clear the cancel flag, and go to REQ.
REQ-023 REQ: req_o SHALL be 1 and wr_o, size_o, addr_o and wdata_o SHALL hold stable, driven from registers; on addr_ok_i the state SHALL go to WAIT; data_ok_i SHALL be ignored in REQ.
REQ-024 WAIT: on data_ok_i, the block SHALL capture rdata_i into the read buffer (reads only; the buffer is unchanged on writes).
REQ-025 WAIT, on data_ok_i: the next state SHALL be DONE when the cancel flag is 0 and IDLE when it is 1.
REQ-026 DONE: the block SHALL hold mem_rdata_o and go to IDLE on pipe_adv_i.
REQ-027 mem_stall_o SHALL equal (IDLE & mem_en_i & ~mem_flush_i) | REQ | WAIT, computed combinationally; it SHALL be 0 in DONE.
REQ-028 Minimum load latency SHALL be: request seen in IDLE at cycle 0, req_o at cycle 1, data_ok at cycle 2, stall low at cycle 3.
REQ-029 mem_flush_i in REQ or WAIT SHALL set the cancel flag only.
REQ-030 A request already driven SHALL stay asserted until addr_ok_i.
REQ-031 A cancelled transaction SHALL drain to IDLE without entering DONE.
REQ-032 Stall SHALL stay high until the cancelled transaction drains.
REQ-033 mem_flush_i in DONE SHALL force IDLE on the next edge.
REQ-034 mem_flush_i in IDLE SHALL issue no request.
REQ-035 In DONE, mem_en_i SHALL be ignored, so the same access is never reissued.
REQ-036 Simultaneous mem_flush_i and data_ok_i in WAIT SHALL be treated as cancelled.
REQ-037 The block SHALL perform no address alignment check; misaligned accesses are blocked upstream by mem_en_i=0.

Reset
REQ-038 While rst=1, the block SHALL asynchronously force state IDLE, cancel flag 0, all latched bus fields 0 and mem_rdata_o = 0.
REQ-039 Outputs during and after reset SHALL be req_o=0, wr_o=0, size_o=0, addr_o=0, wdata_o=0 and mem_stall_o derived from IDLE.
REQ-040 Reset mid-transaction SHALL abandon the transaction; a late data_ok_i after reset in IDLE SHALL be ignored.

Structure
REQ-041 The state encoding and the size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) SHALL live in shared package cpu_bus_pkg.
REQ-042 The block SHALL have no sub-module; the FSM and the buffer registers are inline.

Verification
REQ-043 Word load: addr 0x80001000, size 2, addr_ok at cycle 1, data_ok with 0xDEADBEEF at cycle 2 -> mem_rdata_o=0xDEADBEEF and stall low at cycle 3.
REQ-044 Byte store: wen 0001, wdata 0x000000AB, addr_ok delayed 3 cycles -> req_o held 4 cycles with stable wr=1, size=0, wdata; stall low after data_ok; buffer unchanged.
REQ-045 Flush during WAIT on a load -> stall stays high until data_ok, state returns to IDLE, mem_rdata_o unchanged, no DONE.
REQ-046 DONE with pipe_adv_i=0 for 5 cycles, rdata_i toggling -> mem_rdata_o stable, no new req_o.
REQ-047 rst asserted in WAIT, then data_ok_i pulse after release -> all outputs 0 and no transition out of IDLE.
REQ-048 Back-to-back loads, with pipe_adv in DONE and next mem_en_i -> exactly two req_o handshakes and two distinct buffered values.
